mag_subcarrier_averager: RTL and testbench

//   Consumes the per-subcarrier magnitude stream produced by the complex-to-magnitude stage.

---
 rtl/mag_subcarrier_averager.sv | 159 +++++++++++++++
 tb/tb_mag_subcarrier_averager.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mag_subcarrier_averager.sv
// Per-subcarrier exponential moving average over CSI frames of magnitude samples.
// Emits each updated average with its subcarrier index one cycle after acceptance.
module mag_subcarrier_averager #(
  parameter int DATA_WIDTH    = 32,
  parameter int N_SUBCARRIERS = 64,
  parameter int ALPHA_SHIFT   = 3
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [DATA_WIDTH-1:0]            mag_in,
  input  logic                             mag_valid_in,
  input  logic                             sof_in,
  input  logic                             clear_in,
  output logic [DATA_WIDTH-1:0]            avg_out,
  output logic [$clog2(N_SUBCARRIERS)-1:0] avg_idx_out,
  output logic                             avg_valid_out,
  output logic                             frame_done_out,
  output logic                             short_err_out,
  output logic                             drop_err_out
);

  localparam int IDX_W = $clog2(N_SUBCARRIERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SUBCARRIERS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // avg + floor((x - avg) / 2^ALPHA_SHIFT); the result lies between avg and x, so truncation is exact.
  function automatic logic [DATA_WIDTH-1:0] ema_update(
    input logic [DATA_WIDTH-1:0] avg,
    input logic [DATA_WIDTH-1:0] x,
    input logic                  overwrite
  );
    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH:0] step;
    diff = $signed({1'b0, x}) - $signed({1'b0, avg});
    step = diff >>> ALPHA_SHIFT;
    if (overwrite) begin
      return x;
    end
    return DATA_WIDTH'($unsigned($signed({1'b0, avg}) + step));
  endfunction

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    first_q, first_d;
  logic [DATA_WIDTH-1:0]   avg_q, avg_d;
  logic [IDX_W-1:0]        aidx_q, aidx_d;
  logic                    avld_q, avld_d;
  logic                    fdone_q, fdone_d;
  logic                    short_q, short_d;
  logic                    drop_q, drop_d;

  logic                    accept;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_WIDTH-1:0]   cur_avg;
  logic [DATA_WIDTH-1:0]   new_avg;

  logic [DATA_WIDTH-1:0]   avg_mem [N_SUBCARRIERS];

  // Sample acceptance and frame sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = first_q;
    short_d = short_q;
    drop_d  = drop_q;
    accept  = 1'b0;
    wr_idx  = '0;
    if (clear_in) begin
      state_d = S_IDLE;
      idx_d   = '0;
      first_d = 1'b1;
      short_d = 1'b0;
      drop_d  = 1'b0;
    end else if (mag_valid_in) begin
      case (state_q)
        S_IDLE: begin
          if (sof_in) begin
            accept  = 1'b1;
            wr_idx  = '0;
            idx_d   = '0;
            state_d = S_RUN;
          end else begin
            drop_d = 1'b1;
          end
        end
        S_RUN: begin
          accept = 1'b1;
          if (sof_in) begin
            short_d = 1'b1;
            wr_idx  = '0;
          end else begin
            wr_idx = idx_q + 1'b1;
          end
          idx_d = wr_idx;
          if (!sof_in && wr_idx == LAST_IDX) begin
            state_d = S_IDLE;
            first_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign cur_avg = avg_mem[wr_idx];
  assign new_avg = ema_update(cur_avg, mag_in, first_q);

  always_comb begin
    avg_d   = avg_q;
    aidx_d  = aidx_q;
    avld_d  = accept;
    fdone_d = accept && (wr_idx == LAST_IDX);
    if (accept) begin
      avg_d  = new_avg;
      aidx_d = wr_idx;
    end
  end

  // Control and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      first_q <= 1'b1;
      avg_q   <= '0;
      aidx_q  <= '0;
      avld_q  <= 1'b0;
      fdone_q <= 1'b0;
      short_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      avg_q   <= avg_d;
      aidx_q  <= aidx_d;
      avld_q  <= avld_d;
      fdone_q <= fdone_d;
      short_q <= short_d;
      drop_q  <= drop_d;
    end
  end

  // Average storage is left unreset; first_q forces an overwrite on the first full frame.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      avg_mem[wr_idx] <= new_avg;
    end
  end

  assign avg_out        = avg_q;
  assign avg_idx_out    = aidx_q;
  assign avg_valid_out  = avld_q;
  assign frame_done_out = fdone_q;
  assign short_err_out  = short_q;
  assign drop_err_out   = drop_q;

endmodule

// File: tb/tb_mag_subcarrier_averager.sv
// Bench for mag_subcarrier_averager: directed frames plus randomized traffic
// compared each cycle against a frame-level reference model.
module tb_mag_subcarrier_averager;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int AS = 2;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [DW-1:0] mag_in;
  logic          mag_valid_in;
  logic          sof_in;
  logic          clear_in;
  logic [DW-1:0] avg_out;
  logic [1:0]    avg_idx_out;
  logic          avg_valid_out;
  logic          frame_done_out;
  logic          short_err_out;
  logic          drop_err_out;

  int n_chk  = 0;
  int n_fail = 0;

  mag_subcarrier_averager #(
    .DATA_WIDTH(DW), .N_SUBCARRIERS(N), .ALPHA_SHIFT(AS)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mag_in(mag_in),
    .mag_valid_in(mag_valid_in), .sof_in(sof_in), .clear_in(clear_in),
    .avg_out(avg_out), .avg_idx_out(avg_idx_out), .avg_valid_out(avg_valid_out),
    .frame_done_out(frame_done_out), .short_err_out(short_err_out),
    .drop_err_out(drop_err_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  bit     m_run;
  int     m_idx;
  bit     m_first;
  longint m_mem [N];
  longint e_avg;
  int     e_idx;
  bit     e_vld, e_fd, e_short, e_drop;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint ema(input longint a, input longint x);
    longint d, st;
    d = x - a;
    if (d >= 0) st = d / (longint'(1) << AS);
    else        st = -(((-d) + (longint'(1) << AS) - 1) / (longint'(1) << AS));
    return a + st;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_idx = 0; m_first = 1;
    e_avg = 0; e_idx = 0; e_vld = 0; e_fd = 0; e_short = 0; e_drop = 0;
  endfunction

  function automatic void model_step(input bit clr, input bit v, input bit s, input longint m);
    int k;
    longint nv;
    e_vld = 0; e_fd = 0;
    if (clr) begin
      m_run = 0; m_idx = 0; m_first = 1; e_short = 0; e_drop = 0;
    end else if (v) begin
      if (!m_run && !s) begin
        e_drop = 1;
      end else begin
        if (s) begin
          if (m_run) e_short = 1;
          k = 0;
          m_run = 1;
        end else begin
          k = m_idx + 1;
        end
        nv = m_first ? m : ema(m_mem[k], m);
        m_mem[k] = nv;
        m_idx = k;
        e_avg = nv; e_idx = k; e_vld = 1;
        if (k == N - 1) begin
          m_run = 0; m_first = 0; e_fd = 1;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    chk("avg_valid", longint'(avg_valid_out), longint'(e_vld));
    chk("avg_out", longint'(avg_out), e_avg);
    chk("avg_idx", longint'(avg_idx_out), longint'(e_idx));
    chk("frame_done", longint'(frame_done_out), longint'(e_fd));
    chk("short_err", longint'(short_err_out), longint'(e_short));
    chk("drop_err", longint'(drop_err_out), longint'(e_drop));
  endtask

  task automatic cyc(input bit clr, input bit v, input bit s, input logic [DW-1:0] m);
    clear_in = clr; mag_valid_in = v; sof_in = s; mag_in = m;
    model_step(clr, v, s, longint'(m));
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, DW'($urandom));
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk_in);
    #1;
    check_outputs();
    rst_n_in = 1'b1;
  endtask

  logic [DW-1:0] f1 [N];
  logic [DW-1:0] f2 [N];
  logic [DW-1:0] want3 [N];

  initial begin
    f1 = '{100, 200, 300, 400};
    f2 = '{180, 200, 260, 0};
    want3 = '{90, 150, 217, 225};
    rst_n_in = 1'b0; clear_in = 0; mag_valid_in = 0; sof_in = 0; mag_in = '0;
    @(posedge clk_in);
    #1;
    apply_reset();

    // First frame overwrites, then EMA, then decay toward zero with flooring
    for (int i = 0; i < N; i++) begin
      cyc(0, 1, i == 0, f1[i]);
      chk("f1_value", longint'(avg_out), longint'(f1[i]));
    end
    for (int i = 0; i < N; i++) cyc(0, 1, i == 0, f2[i]);
    for (int i = 0; i < N; i++) begin
      cyc(0, 1, i == 0, '0);
      chk("f3_value", longint'(avg_out), longint'(want3[i]));
    end
    idle(2);

    // Same frame with idle gaps of 0-3 cycles
    for (int i = 0; i < N; i++) begin
      cyc(0, 1, i == 0, f2[i]);
      idle(i);
    end

    // Drops while idle after reset
    apply_reset();
    cyc(0, 1, 0, 32'd7);
    cyc(0, 1, 0, 32'd9);
    idle(1);
    for (int i = 0; i < N; i++) cyc(0, 1, i == 0, DW'(i * 11));
    cyc(1, 1, 0, 32'd5);
    idle(1);

    // Short frame during the first frame
    apply_reset();
    cyc(0, 1, 1, 32'd1000);
    cyc(0, 1, 0, 32'd2000);
    for (int i = 0; i < N; i++) cyc(0, 1, i == 0, DW'(10 + i));
    for (int i = 0; i < N; i++) cyc(0, 1, i == 0, DW'(500 * (i + 1)));

    // Asynchronous reset mid-frame, then samples without sof are dropped
    cyc(0, 1, 1, 32'd77);
    cyc(0, 1, 0, 32'd88);
    apply_reset();
    cyc(0, 1, 0, 32'd99);
    cyc(0, 1, 0, 32'd99);

    // Clear then overwrite frame
    cyc(1, 0, 0, '0);
    for (int i = 0; i < N; i++) begin
      cyc(0, 1, i == 0, 32'd50);
      chk("clear_overwrite", longint'(avg_out), 50);
    end

    // Randomized traffic: mostly well-formed frames with gaps, occasional errors and clears
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)       cyc(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, DW'($urandom));
      else if (r < 40) cyc(0, 0, 0, DW'($urandom));
      else if (r < 45) cyc(0, 1, 1, DW'($urandom));
      else if (r < 48) cyc(0, 1, 0, DW'($urandom));
      else             cyc(0, 1, !m_run, DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
